ex_mem_stage_reg: RTL

//  Parametrised EX->MEM pipeline stage register with valid/ready handshake, flush and stall accounting.

---
 rtl/ex_mem_stage_reg.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX->MEM stage register with valid/ready handshake, flush and stall counter (optional skid entry: EX_MEM_SKID_EN)
module ex_mem_stage_reg #(
    parameter int                N          = 32,
    parameter int                NUM_WORDS  = 4,
    parameter int                CTRL_W     = 10,
    parameter int                REG_ADDR_W = 5,
    parameter logic [CTRL_W-1:0] CTRL_RESET = '0,
    parameter int                CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_WORDS*N-1:0] in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [REG_ADDR_W-1:0]  in_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_WORDS*N-1:0] out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [REG_ADDR_W-1:0]  out_rd,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic accept;
    logic stalled;

    assign stalled = out_valid && !out_ready;
    assign accept  = in_valid && in_ready;

    // Back-pressure accounting; saturates instead of wrapping, survives flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef EX_MEM_SKID_EN
    logic                   skid_valid;
    logic [NUM_WORDS*N-1:0] skid_data;
    logic [CTRL_W-1:0]      skid_ctrl;
    logic [REG_ADDR_W-1:0]  skid_rd;

    // in_ready depends only on state and reset/flush, never on out_ready.
    assign in_ready = !reset && !flush && !skid_valid;

    // Output register plus one skid slot; skid always drains before new input.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= CTRL_RESET;
            out_rd     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= CTRL_RESET;
            skid_rd    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_ctrl   <= CTRL_RESET;
            out_rd     <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= CTRL_RESET;
            skid_rd    <= '0;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_ctrl   <= skid_ctrl;
                out_rd     <= skid_rd;
                skid_valid <= 1'b0;
                skid_ctrl  <= CTRL_RESET;
                skid_rd    <= '0;
            end
        end else if (accept) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_ctrl  <= in_ctrl;
                out_rd    <= in_rd;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                skid_ctrl  <= in_ctrl;
                skid_rd    <= in_rd;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_RESET;
            out_rd    <= '0;
        end
    end
`else
    // Single entry: can take a new entry when empty or when the current one leaves.
    assign in_ready = !reset && !flush && (!out_valid || out_ready);

    // Load on accept, bubble on flush or drain; data word is held when emptied.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= CTRL_RESET;
            out_rd    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_RESET;
            out_rd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_ctrl  <= in_ctrl;
            out_rd    <= in_rd;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_RESET;
            out_rd    <= '0;
        end
    end
`endif

endmodule
